// File: rtl/piano_pkg.sv
// Shared types, note tuning table and arithmetic helpers for the piano tone datapath.
package piano_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OUT} fsm_t;

  localparam int NUM_NOTES = 10;

  // Phase increments for 32-bit accumulators at 48 kHz, C4 upward through E5.
  localparam logic [31:0] NOTE_TW [NUM_NOTES] = '{
    32'd23410279,  // C4
    32'd26276681,  // D4
    32'd29494578,  // E4
    32'd31248410,  // F4
    32'd35075155,  // G4
    32'd39370535,  // A4
    32'd44191930,  // B4
    32'd46820558,  // C5
    32'd52553362,  // D5
    32'd58989156   // E5
  };

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // round(32767 * sin(2*pi*k / 2^addr_w)), rounding half away from zero.
  function automatic int sine_entry(input int k, input int addr_w);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << addr_w));
    if (x >= 0.0) return $rtoi(x + 0.5);
    return $rtoi(x - 0.5);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-cycle signed sine table with a single registered read port.
module sine_rom
  import piano_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 16,
  parameter string INIT_FILE = "realsintable.hex"
) (
  input  logic                     clk,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic signed [DATA_W-1:0] rom [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign rom[gi] = DATA_W'(sine_entry(gi, ADDR_W));
    end
  endgenerate

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic sine synthesiser: one phase accumulator per voice sharing one sine ROM,
// producing one summed, scaled and saturated sample per accepted FIFO write.
module poly_tone_synth
  import piano_pkg::*;
#(
  parameter int    NUM_VOICES = 10,
  parameter int    PHASE_W    = 32,
  parameter int    LUT_ADDR_W = 10,
  parameter int    LUT_DATA_W = 16,
  parameter int    SAMPLE_W   = 32,
  parameter int    GAIN_SHIFT = 8,
  parameter string ROM_FILE   = "realsintable.hex"
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_VOICES-1:0]         voice_on,
  input  logic [NUM_VOICES*PHASE_W-1:0] tuning_word,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [SAMPLE_W-1:0]           left_channel_audio_out,
  output logic [SAMPLE_W-1:0]           right_channel_audio_out
);

  localparam int ACC_W = LUT_DATA_W + $clog2(NUM_VOICES);
  localparam int V_W   = $clog2(NUM_VOICES + 1);
  localparam logic [V_W-1:0] LAST_V = V_W'(NUM_VOICES);

  fsm_t                     state_reg, state_next;
  logic [V_W-1:0]           v_reg, v_next, v_sel;
  logic signed [ACC_W-1:0]  acc_reg, acc_next, term;
  logic                     on_d_reg;
  logic [PHASE_W-1:0]       phase_reg [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample_reg, sample_next;
  logic signed [63:0]       scaled;
  logic [LUT_ADDR_W-1:0]    rom_addr;
  logic signed [LUT_DATA_W-1:0] rom_data;
  logic                     in_voice;

  sine_rom #(
    .ADDR_W   (LUT_ADDR_W),
    .DATA_W   (LUT_DATA_W),
    .INIT_FILE(ROM_FILE)
  ) u_rom (
    .clk (CLOCK_50),
    .addr(rom_addr),
    .data(rom_data)
  );

  // The final RUN cycle only drains the last ROM read; no voice is addressed then.
  always_comb begin
    in_voice = (state_reg == RUN) && (v_reg < LAST_V);
    v_sel    = in_voice ? v_reg : '0;
    rom_addr = phase_reg[v_sel][PHASE_W-1 -: LUT_ADDR_W];
    term     = on_d_reg ? {{(ACC_W-LUT_DATA_W){rom_data[LUT_DATA_W-1]}}, rom_data} : '0;
    acc_next = acc_reg + term;
    scaled   = {{(64-ACC_W){acc_next[ACC_W-1]}}, acc_next} <<< GAIN_SHIFT;
    sample_next = SAMPLE_W'(saturate(scaled, SAMPLE_W));
  end

  always_comb begin
    state_next      = state_reg;
    v_next          = v_reg;
    write_audio_out = 1'b0;
    case (state_reg)
      IDLE: begin
        if (audio_out_allowed) begin
          state_next = RUN;
          v_next     = '0;
        end
      end
      RUN: begin
        if (v_reg == LAST_V) state_next = OUT;
        else                 v_next     = v_reg + 1'b1;
      end
      OUT: begin
        write_audio_out = audio_out_allowed && !reset;
        if (audio_out_allowed) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      v_reg      <= '0;
      acc_reg    <= '0;
      on_d_reg   <= 1'b0;
      sample_reg <= '0;
    end else begin
      state_reg <= state_next;
      v_reg     <= v_next;
      case (state_reg)
        IDLE: begin
          acc_reg  <= '0;
          on_d_reg <= 1'b0;
        end
        RUN: begin
          acc_reg  <= acc_next;
          on_d_reg <= in_voice && voice_on[v_sel];
          if (v_reg == LAST_V) sample_reg <= sample_next;
        end
        default: on_d_reg <= 1'b0;
      endcase
    end
  end

  // A silent voice parks at phase 0 so it always restarts on a zero crossing.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          phase_reg[gi] <= '0;
        end else if (in_voice && v_reg == V_W'(gi)) begin
          phase_reg[gi] <= voice_on[gi] ? phase_reg[gi] + tuning_word[gi*PHASE_W +: PHASE_W] : '0;
        end
      end
    end
  endgenerate

  assign left_channel_audio_out  = sample_reg;
  assign right_channel_audio_out = sample_reg;

endmodule
